// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage. It owns the PC, drives the instruction memory
// address, and loads the IF/ID pipeline register from the combinational
// memory read data. A small three-state FSM sequences the unit:
//   START : one idle cycle after reset; nothing is committed.
//   RUN   : normal fetch, honouring stall and branch redirects.
//   HALT  : entered when HALT_WORD is fetched; only a branch leaves it.
//
// Optional feature (compile-time macro IF_DELAY_SLOT_EN):
//   defined   - the word fetched in a RUN branch cycle is committed to IF/ID
//               as a delay-slot instruction (a HALT_WORD there becomes a
//               bubble and does not halt).
//   undefined - the word fetched in a branch cycle is squashed (bubble).
//
// Handshake/timing contract: there is no valid/ready flow control on the
// inputs. stall and branch_taken are sampled on every rising edge;
// branch_taken wins over stall. imem_data must be the combinational read of
// imem_addr within the same cycle. ifid_valid qualifies ifid_instr/ifid_pc1
// in the cycle after the edge that loaded them.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hazard hold request (ignored in HALT)
//   branch_taken   in   1   redirect request from a later stage
//   branch_target  in  12   redirect PC
//   imem_addr      out 12   instruction memory address (= PC)
//   imem_data      in  19   instruction word at imem_addr
//   ifid_instr     out 19   registered instruction to decode
//   ifid_pc1       out 12   registered PC+1 of ifid_instr
//   ifid_valid     out  1   ifid_instr is a real instruction
//   halted         out  1   registered, high while the FSM is in HALT
//   fetch_count    out 16   instructions delivered with ifid_valid=1 (wraps)
//   state_dbg      out  2   current FSM state encoding, for debug/checkers
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [11:0] RESET_PC  = 12'd0,
    parameter logic [18:0] NOP_WORD  = 19'd0,
    parameter logic [18:0] HALT_WORD = 19'h7FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [11:0] branch_target,
    output logic [11:0] imem_addr,
    input  logic [18:0] imem_data,
    output logic [18:0] ifid_instr,
    output logic [11:0] ifid_pc1,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] pc;
    logic [11:0] pc_inc;
    logic        fetch_is_halt;
    logic        slot_commit;

    // 12-bit modulo increment; FFF rolls to 000 with no carry out.
    assign pc_inc        = pc + 12'd1;
    assign fetch_is_halt = (imem_data == HALT_WORD);
    assign imem_addr     = pc;
    assign state_dbg     = state;

    // Whether the word fetched alongside a RUN-state branch is kept.
`ifdef IF_DELAY_SLOT_EN
    assign slot_commit = !fetch_is_halt;
`else
    assign slot_commit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_START;
            pc          <= RESET_PC;
            ifid_instr  <= NOP_WORD;
            ifid_pc1    <= 12'd0;
            ifid_valid  <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'd0;
        end else begin
            case (state)
                ST_START: begin
                    // No fetch is committed here; IF/ID still holds the reset
                    // bubble. A branch arriving now only redirects the PC.
                    state <= ST_RUN;
                    if (branch_taken) begin
                        pc         <= branch_target;
                        ifid_instr <= NOP_WORD;
                        ifid_pc1   <= pc_inc;
                        ifid_valid <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                        if (slot_commit) begin
                            ifid_instr  <= imem_data;
                            ifid_pc1    <= pc_inc;
                            ifid_valid  <= 1'b1;
                            fetch_count <= fetch_count + 16'd1;
                        end else begin
                            ifid_instr <= NOP_WORD;
                            ifid_pc1   <= pc_inc;
                            ifid_valid <= 1'b0;
                        end
                    end else if (!stall) begin
                        if (fetch_is_halt) begin
                            // PC stays on the halt word so a later redirect is
                            // the only way forward.
                            ifid_instr <= NOP_WORD;
                            ifid_pc1   <= pc_inc;
                            ifid_valid <= 1'b0;
                            state      <= ST_HALT;
                            halted     <= 1'b1;
                        end else begin
                            ifid_instr  <= imem_data;
                            ifid_pc1    <= pc_inc;
                            ifid_valid  <= 1'b1;
                            pc          <= pc_inc;
                            fetch_count <= fetch_count + 16'd1;
                        end
                    end
                end

                ST_HALT: begin
                    // Stall is irrelevant here; only an older in-flight branch
                    // can restart fetch.
                    if (branch_taken) begin
                        pc         <= branch_target;
                        ifid_instr <= NOP_WORD;
                        ifid_pc1   <= pc_inc;
                        ifid_valid <= 1'b0;
                        state      <= ST_RUN;
                        halted     <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_START;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
